// File: rtl/axi_write_burst_ctrl.sv
// Burst scheduler for the DDR FIFO write path: issues one AXI INCR write burst
// whenever a full burst is staged, then walks a circular DDR write pointer.
module axi_write_burst_ctrl #(
    parameter int unsigned           ADDR_W     = 32,
    parameter int unsigned           DATA_BYTES = 16,
    parameter int unsigned           BURST_LEN  = 16,
    parameter logic [ADDR_W-1:0]     BASE_ADDR  = '0,
    parameter logic [ADDR_W-1:0]     REGION_SZ  = ADDR_W'(32'h0010_0000),
    parameter int unsigned           CNT_W      = 10
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    input  logic              enable,
    input  logic [CNT_W-1:0]  fifo_rd_count,
    output logic              start_single_burst_write,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [7:0]        M_AXI_AWLEN,
    output logic [2:0]        M_AXI_AWSIZE,
    output logic [1:0]        M_AXI_AWBURST,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    input  logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic              M_AXI_WLAST,
    input  logic              M_AXI_BVALID,
    input  logic [1:0]        M_AXI_BRESP,
    output logic              M_AXI_BREADY,
    output logic [31:0]       committed_bursts,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              write_error,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_BYTES);
    localparam logic [ADDR_W-1:0] REGION_END  = BASE_ADDR + REGION_SZ;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic              aw_done, aw_done_n;
    logic              w_done, w_done_n;
    logic              awvalid_n;
    logic [ADDR_W-1:0] awaddr_n;
    logic              bready_n;
    logic              start_n;
    logic [31:0]       committed_n;
    logic [ADDR_W-1:0] wr_ptr_n;
    logic [ADDR_W-1:0] ptr_inc;
    logic              error_n;
    logic              aw_hs;
    logic              w_last_hs;

    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(DATA_BYTES));
    assign M_AXI_AWBURST = 2'b01;
    assign busy          = (state != IDLE);

    assign aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_last_hs = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST;
    assign ptr_inc   = wr_ptr + BURST_BYTES;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state                    <= IDLE;
            aw_done                  <= 1'b0;
            w_done                   <= 1'b0;
            M_AXI_AWVALID            <= 1'b0;
            M_AXI_AWADDR             <= BASE_ADDR;
            M_AXI_BREADY             <= 1'b0;
            start_single_burst_write <= 1'b0;
            committed_bursts         <= '0;
            wr_ptr                   <= BASE_ADDR;
            write_error              <= 1'b0;
        end else begin
            state                    <= state_n;
            aw_done                  <= aw_done_n;
            w_done                   <= w_done_n;
            M_AXI_AWVALID            <= awvalid_n;
            M_AXI_AWADDR             <= awaddr_n;
            M_AXI_BREADY             <= bready_n;
            start_single_burst_write <= start_n;
            committed_bursts         <= committed_n;
            wr_ptr                   <= wr_ptr_n;
            write_error              <= error_n;
        end
    end

    always_comb begin
        state_n     = state;
        aw_done_n   = aw_done;
        w_done_n    = w_done;
        awvalid_n   = M_AXI_AWVALID;
        awaddr_n    = M_AXI_AWADDR;
        bready_n    = M_AXI_BREADY;
        start_n     = 1'b0;
        committed_n = committed_bursts;
        wr_ptr_n    = wr_ptr;
        error_n     = write_error;

        case (state)
            IDLE: begin
                if (enable && (32'(fifo_rd_count) >= BURST_LEN)) begin
                    state_n   = ISSUE;
                    start_n   = 1'b1;
                    awvalid_n = 1'b1;
                    awaddr_n  = wr_ptr;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            // ISSUE waits on the address handshake, XFER only on WLAST;
            // both flags are tracked so either may complete first.
            ISSUE, XFER: begin
                if (aw_hs) begin
                    awvalid_n = 1'b0;
                end
                aw_done_n = aw_done || aw_hs;
                w_done_n  = w_done || w_last_hs;
                if (aw_done_n && w_done_n) begin
                    state_n  = RESP;
                    bready_n = 1'b1;
                end else if (aw_done_n) begin
                    state_n = XFER;
                end else begin
                    state_n = ISSUE;
                end
            end
            RESP: begin
                if (M_AXI_BVALID && M_AXI_BREADY) begin
                    bready_n    = 1'b0;
                    committed_n = committed_bursts + 32'd1;
                    wr_ptr_n    = (ptr_inc == REGION_END) ? BASE_ADDR : ptr_inc;
                    if (M_AXI_BRESP != 2'b00) begin
                        error_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_write_burst_ctrl.sv
// Directed bench for axi_write_burst_ctrl with a 512-byte ring at 0x1000.
module tb_axi_write_burst_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [9:0]  fifo_cnt;
    logic        start;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic [31:0] committed;
    logic [31:0] wr_ptr;
    logic        err;
    logic        busy;

    int unsigned total;
    int unsigned bad;
    logic [31:0] a0, a1, a2;

    axi_write_burst_ctrl #(
        .ADDR_W     (32),
        .DATA_BYTES (16),
        .BURST_LEN  (16),
        .BASE_ADDR  (32'h0000_1000),
        .REGION_SZ  (32'h0000_0200),
        .CNT_W      (10)
    ) dut (
        .M_AXI_ACLK               (clk),
        .M_AXI_ARESETN            (rst_n),
        .enable                   (enable),
        .fifo_rd_count            (fifo_cnt),
        .start_single_burst_write (start),
        .M_AXI_AWADDR             (awaddr),
        .M_AXI_AWLEN              (awlen),
        .M_AXI_AWSIZE             (awsize),
        .M_AXI_AWBURST            (awburst),
        .M_AXI_AWVALID            (awvalid),
        .M_AXI_AWREADY            (awready),
        .M_AXI_WVALID             (wvalid),
        .M_AXI_WREADY             (wready),
        .M_AXI_WLAST              (wlast),
        .M_AXI_BVALID             (bvalid),
        .M_AXI_BRESP              (bresp),
        .M_AXI_BREADY             (bready),
        .committed_bursts         (committed),
        .wr_ptr                   (wr_ptr),
        .write_error              (err),
        .busy                     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full burst with AW and WLAST handshaking in the same cycle.
    task automatic run_burst(input logic [1:0] resp, output logic [31:0] addr);
        int unsigned n;
        n = 0;
        fifo_cnt = 10'd16;
        while (!start && n < 10) begin
            tick();
            n++;
        end
        chk("start_seen", {31'd0, start}, 32'd1);
        addr = awaddr;
        fifo_cnt = 10'd0;
        awready = 1'b1; wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
        tick();
        awready = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        chk("bready_up", {31'd0, bready}, 32'd1);
        bvalid = 1'b1; bresp = resp;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        chk("bready_down", {31'd0, bready}, 32'd0);
    endtask

    initial begin
        int unsigned starts;
        total = 0; bad = 0;
        rst_n = 1'b0; enable = 1'b0; fifo_cnt = 10'd0;
        awready = 1'b0; wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
        bvalid = 1'b0; bresp = 2'b00;
        tick(); tick();

        chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst_bready", {31'd0, bready}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_committed", committed, 32'd0);
        chk("rst_wr_ptr", wr_ptr, 32'h1000);
        rst_n = 1'b1;
        tick();

        // 1: one below threshold, then exactly at threshold
        enable = 1'b1; fifo_cnt = 10'd15;
        tick(); tick(); tick();
        chk("t1_no_start", {31'd0, start}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        fifo_cnt = 10'd16;
        tick();
        fifo_cnt = 10'd0;
        chk("t1_start", {31'd0, start}, 32'd1);
        chk("t1_awvalid", {31'd0, awvalid}, 32'd1);
        chk("t1_awaddr", awaddr, 32'h1000);
        chk("t1_awlen", {24'd0, awlen}, 32'd15);
        chk("t1_awsize", {29'd0, awsize}, 32'd4);
        chk("t1_awburst", {30'd0, awburst}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);

        // 2: WLAST first, AWREADY 5 cycles late
        wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        chk("t2_single_pulse", {31'd0, start}, 32'd0);
        tick(); tick(); tick(); tick();
        chk("t2_no_bready_yet", {31'd0, bready}, 32'd0);
        chk("t2_awvalid_held", {31'd0, awvalid}, 32'd1);
        chk("t2_awaddr_held", awaddr, 32'h1000);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("t2_awvalid_drop", {31'd0, awvalid}, 32'd0);
        chk("t2_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("t2_committed", committed, 32'd1);
        chk("t2_wr_ptr", wr_ptr, 32'h1100);
        chk("t2_bready_drop", {31'd0, bready}, 32'd0);
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // 3: ring wrap over three bursts from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_burst(2'b00, a0);
        run_burst(2'b00, a1);
        run_burst(2'b00, a2);
        chk("t3_addr0", a0, 32'h1000);
        chk("t3_addr1", a1, 32'h1100);
        chk("t3_addr2", a2, 32'h1000);
        chk("t3_committed", committed, 32'd3);
        chk("t3_wr_ptr", wr_ptr, 32'h1100);

        // 4: SLVERR is sticky and still counted
        run_burst(2'b10, a0);
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_committed", committed, 32'd4);
        chk("t4_addr", a0, 32'h1100);
        run_burst(2'b00, a1);
        chk("t4_err_sticky", {31'd0, err}, 32'd1);
        chk("t4_committed2", committed, 32'd5);
        chk("t4_addr2", a1, 32'h1000);

        // 5: asynchronous reset during XFER
        fifo_cnt = 10'd16;
        tick();
        fifo_cnt = 10'd0;
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("t5_in_xfer", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_awvalid", {31'd0, awvalid}, 32'd0);
        chk("t5_bready", {31'd0, bready}, 32'd0);
        chk("t5_wr_ptr", wr_ptr, 32'h1000);
        chk("t5_committed", committed, 32'd0);
        chk("t5_err", {31'd0, err}, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 6: enable dropped in ISSUE, AW completes before WLAST
        fifo_cnt = 10'd16;
        tick();
        enable = 1'b0;
        chk("t6_start", {31'd0, start}, 32'd1);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("t6_xfer_busy", {31'd0, busy}, 32'd1);
        chk("t6_no_bready", {31'd0, bready}, 32'd0);
        wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        chk("t6_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("t6_committed", committed, 32'd1);
        chk("t6_wr_ptr", wr_ptr, 32'h1100);
        starts = 0;
        bvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (start || busy) starts++;
        end
        bvalid = 1'b0;
        chk("t6_blocked", starts, 32'd0);
        chk("t6_bvalid_ignored", committed, 32'd1);
        chk("t6_bready_idle", {31'd0, bready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
